// File: rtl/dino_jump_ctrl.sv
// Dino vertical-motion controller: jump/duck capture, per-tick gravity integration, replay reset.
// Optional build macro DINO_FAST_FALL_EN: holding duck while airborne forces a max-speed fall.
module dino_jump_ctrl #(
    parameter int GROUND_Y = 248,
    parameter int CEIL_Y   = 16,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 15,
    parameter int JUMP_BIT = 0,
    parameter int DUCK_BIT = 1,
    parameter int RUN_DIV  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  controller_report,
    input  logic        tick,
    input  logic        game_over,
    output logic [10:0] dino_y,
    output logic        airborne,
    output logic        ducking,
    output logic        run_frame,
    output logic [7:0]  jump_count,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_GROUND = 2'd0;
    localparam logic [1:0] S_DUCK   = 2'd1;
    localparam logic [1:0] S_RISE   = 2'd2;
    localparam logic [1:0] S_FALL   = 2'd3;

    localparam logic [10:0]        LP_GROUND_Y   = 11'(GROUND_Y);
    localparam logic signed [11:0] LP_CEIL_Y     = 12'(CEIL_Y);
    localparam logic [7:0]         LP_JUMP_VEL   = 8'(JUMP_VEL);
    localparam logic [7:0]         LP_GRAVITY    = 8'(GRAVITY);
    localparam logic [7:0]         LP_MAX_FALL   = 8'(MAX_FALL);
    localparam logic [7:0]         LP_RUN_DIV_M1 = 8'(RUN_DIV - 1);

    logic [1:0]  r_sync1, r_sync2;
    logic        r_prev_jump, r_jump_req, r_go_prev;
    logic [1:0]  r_state, w_state_nxt;
    logic [10:0] r_y, w_y_nxt;
    logic [7:0]  r_vel, w_vel_nxt;
    logic [7:0]  r_count, w_count_nxt;
    logic [7:0]  r_div, w_div_nxt;
    logic        r_frame, w_frame_nxt;
    logic        r_airborne, r_ducking;
    logic        w_airborne_nxt, w_ducking_nxt;

    logic        w_jump_edge, w_duck, w_replay, w_step, w_fast;
    logic        w_unused;
    logic [7:0]  w_fall_base, w_fall_nv, w_rise_vel;
    logic [8:0]  w_fall_sum;
    logic [11:0] w_fall_y;
    logic signed [11:0] w_rise_y;

    assign w_unused    = &{1'b0, controller_report};
    assign w_jump_edge = r_sync2[0] & ~r_prev_jump;
    assign w_duck      = r_sync2[1];
    // A game_over falling edge is a replay and overrides any tick in the same cycle.
    assign w_replay    = r_go_prev & ~game_over;
    assign w_step      = tick & ~game_over & ~w_replay;

`ifdef DINO_FAST_FALL_EN
    assign w_fast = w_duck;
`else
    assign w_fast = 1'b0;
`endif

    assign w_fall_base = w_fast ? LP_MAX_FALL : r_vel;
    assign w_fall_sum  = {1'b0, w_fall_base} + {1'b0, LP_GRAVITY};
    assign w_fall_nv   = (w_fall_sum > {1'b0, LP_MAX_FALL}) ? LP_MAX_FALL : w_fall_sum[7:0];
    assign w_fall_y    = {1'b0, r_y} + {4'b0, w_fall_nv};
    assign w_rise_y    = $signed({1'b0, r_y}) - $signed({4'b0, r_vel});
    assign w_rise_vel  = r_vel - LP_GRAVITY;

    // Input capture runs regardless of game_over; a jump edge on a tick cycle is kept for the next tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= 2'b00;
            r_sync2     <= 2'b00;
            r_prev_jump <= 1'b0;
            r_jump_req  <= 1'b0;
            r_go_prev   <= 1'b0;
        end else begin
            r_sync1     <= {controller_report[DUCK_BIT], controller_report[JUMP_BIT]};
            r_sync2     <= r_sync1;
            r_prev_jump <= r_sync2[0];
            r_go_prev   <= game_over;
            if (w_replay)
                r_jump_req <= 1'b0;
            else if (tick)
                r_jump_req <= w_jump_edge;
            else if (w_jump_edge)
                r_jump_req <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_GROUND;
            r_y        <= LP_GROUND_Y;
            r_vel      <= 8'd0;
            r_count    <= 8'd0;
            r_div      <= 8'd0;
            r_frame    <= 1'b0;
            r_airborne <= 1'b0;
            r_ducking  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_y        <= w_y_nxt;
            r_vel      <= w_vel_nxt;
            r_count    <= w_count_nxt;
            r_div      <= w_div_nxt;
            r_frame    <= w_frame_nxt;
            r_airborne <= w_airborne_nxt;
            r_ducking  <= w_ducking_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_vel_nxt   = r_vel;
        w_count_nxt = r_count;
        w_div_nxt   = r_div;
        w_frame_nxt = r_frame;
        if (w_replay) begin
            w_state_nxt = S_GROUND;
            w_y_nxt     = LP_GROUND_Y;
            w_vel_nxt   = 8'd0;
            w_count_nxt = 8'd0;
            w_div_nxt   = 8'd0;
        end else if (w_step) begin
            case (r_state)
                S_GROUND, S_DUCK: begin
                    if (r_jump_req) begin
                        w_state_nxt = S_RISE;
                        w_vel_nxt   = LP_JUMP_VEL;
                        w_div_nxt   = 8'd0;
                        w_count_nxt = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                    end else begin
                        w_state_nxt = w_duck ? S_DUCK : S_GROUND;
                        if (r_div == LP_RUN_DIV_M1) begin
                            w_div_nxt   = 8'd0;
                            w_frame_nxt = ~r_frame;
                        end else begin
                            w_div_nxt = r_div + 8'd1;
                        end
                    end
                end
                default: begin
                    if (r_state == S_RISE && !w_fast) begin
                        if (w_rise_y < LP_CEIL_Y) begin
                            w_y_nxt     = LP_CEIL_Y[10:0];
                            w_vel_nxt   = 8'd0;
                            w_state_nxt = S_FALL;
                        end else begin
                            w_y_nxt   = w_rise_y[10:0];
                            w_vel_nxt = w_rise_vel;
                            if (w_rise_vel == 8'd0)
                                w_state_nxt = S_FALL;
                        end
                    end else if (w_fall_y >= {1'b0, LP_GROUND_Y}) begin
                        w_y_nxt     = LP_GROUND_Y;
                        w_vel_nxt   = 8'd0;
                        w_state_nxt = S_GROUND;
                    end else begin
                        w_y_nxt     = w_fall_y[10:0];
                        w_vel_nxt   = w_fall_nv;
                        w_state_nxt = S_FALL;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_airborne_nxt = (w_state_nxt == S_RISE) || (w_state_nxt == S_FALL);
        w_ducking_nxt  = (w_state_nxt == S_DUCK);
    end

    assign dino_y     = r_y;
    assign airborne   = r_airborne;
    assign ducking    = r_ducking;
    assign run_frame  = r_frame;
    assign jump_count = r_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Self-checking bench for dino_jump_ctrl: directed arcs plus random button/game_over traffic vs a reference model.
module tb_dino_jump_ctrl;
    localparam int GROUND_Y = 248;
    localparam int CEIL_Y   = 16;
    localparam int JUMP_VEL = 12;
    localparam int GRAVITY  = 1;
    localparam int MAX_FALL = 15;
    localparam int RUN_DIV  = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  controller_report;
    logic        tick;
    logic        game_over;
    logic [10:0] dino_y;
    logic        airborne, ducking, run_frame;
    logic [7:0]  jump_count;
    logic [1:0]  dbg_state;

    dino_jump_ctrl dut (
        .clk(clk), .reset(reset), .controller_report(controller_report), .tick(tick),
        .game_over(game_over), .dino_y(dino_y), .airborne(airborne), .ducking(ducking),
        .run_frame(run_frame), .jump_count(jump_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [21:0] exp_q[$];

    // Reference model: position/speed/mode per physics tick.
    int   m_y, m_vel, m_div, m_count;
    bit   m_up, m_air, m_duck, m_frame;
    bit   m_prev_jb, m_prev_go, m_press, m_go;
    logic [7:0] m_rep;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_replay();
        m_y = GROUND_Y; m_vel = 0; m_up = 0; m_air = 0; m_duck = 0; m_count = 0; m_div = 0;
    endtask

    task automatic model_reset();
        model_replay();
        m_frame = 0; m_prev_jb = 0; m_prev_go = 0; m_press = 0; m_go = 0; m_rep = 8'h00;
    endtask

    task automatic model_apply(input logic [7:0] rep, input bit go);
        if (m_prev_go && !go) model_replay();
        m_prev_go = go;
        m_go      = go;
        m_press   = rep[0] && !m_prev_jb;
        m_prev_jb = rep[0];
        m_rep     = rep;
    endtask

    task automatic model_tick();
        bit duck, fast;
        int nv;
        if (m_go) return;
        duck = m_rep[1];
        if (!m_air) begin
            if (m_press) begin
                m_air = 1; m_up = 1; m_vel = JUMP_VEL; m_duck = 0; m_div = 0;
                if (m_count < 255) m_count++;
            end else begin
                m_duck = duck;
                m_div++;
                if (m_div == RUN_DIV) begin
                    m_div = 0;
                    m_frame = !m_frame;
                end
            end
        end else begin
            fast = 0;
`ifdef DINO_FAST_FALL_EN
            fast = duck;
`endif
            if (fast) begin
                m_up = 0;
                m_vel = MAX_FALL;
            end
            if (m_up) begin
                if (m_y - m_vel < CEIL_Y) begin
                    m_y = CEIL_Y; m_vel = 0; m_up = 0;
                end else begin
                    m_y = m_y - m_vel;
                    m_vel = m_vel - GRAVITY;
                    if (m_vel == 0) m_up = 0;
                end
            end else begin
                nv = m_vel + GRAVITY;
                if (nv > MAX_FALL) nv = MAX_FALL;
                if (m_y + nv >= GROUND_Y) begin
                    m_y = GROUND_Y; m_vel = 0; m_air = 0;
                end else begin
                    m_y = m_y + nv;
                    m_vel = nv;
                end
            end
        end
    endtask

    task automatic push_expected();
        exp_q.push_back({11'(m_y), m_air, m_duck, m_frame, 8'(m_count)});
    endtask

    task automatic compare_outputs(input string tag);
        logic [21:0] e;
        e = exp_q.pop_front();
        check({tag, "_y"},     32'(dino_y),     32'(e[21:11]));
        check({tag, "_air"},   32'(airborne),   32'(e[10]));
        check({tag, "_duck"},  32'(ducking),    32'(e[9]));
        check({tag, "_frame"}, 32'(run_frame),  32'(e[8]));
        check({tag, "_count"}, 32'(jump_count), 32'(e[7:0]));
    endtask

    task automatic step(input string tag, input logic [7:0] rep, input bit go);
        controller_report = rep;
        game_over = go;
        model_apply(rep, go);
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        model_tick();
        push_expected();
        cyc(2);
        compare_outputs(tag);
    endtask

    task automatic do_reset();
        controller_report = 8'h00;
        game_over = 1'b0;
        tick = 1'b0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        model_reset();
        cyc(2);
    endtask

    initial begin
        logic [7:0] rep;
        bit go;
        reset = 1'b1;
        controller_report = 8'h00;
        tick = 1'b0;
        game_over = 1'b0;
        cyc(3);
        check("rst_y", 32'(dino_y), 32'(GROUND_Y));
        check("rst_air", 32'(airborne), 0);
        check("rst_duck", 32'(ducking), 0);
        check("rst_frame", 32'(run_frame), 0);
        check("rst_count", 32'(jump_count), 0);
        reset = 1'b0;
        model_reset();
        cyc(2);

        // Single jump arc.
        step("arc_start", 8'h01, 0);
        for (int k = 1; k <= 30; k++) begin
            step("arc", 8'h00, 0);
            if (k == 1)  check("arc_y_t1", 32'(dino_y), 236);
            if (k == 2)  check("arc_y_t2", 32'(dino_y), 225);
            if (k == 12) check("arc_y_apex", 32'(dino_y), 170);
            if (k == 23) check("arc_air_t23", 32'(airborne), 1);
            if (k == 24) begin
                check("arc_air_t24", 32'(airborne), 0);
                check("arc_y_t24", 32'(dino_y), 248);
            end
        end
        check("arc_count", 32'(jump_count), 1);

        // Reset in the middle of a jump.
        step("mid_start", 8'h01, 0);
        for (int k = 0; k < 5; k++) step("mid", 8'h00, 0);
        controller_report = 8'h00;
        reset = 1'b1;
        cyc(1);
        check("midrst_y", 32'(dino_y), 248);
        check("midrst_air", 32'(airborne), 0);
        check("midrst_count", 32'(jump_count), 0);
        reset = 1'b0;
        model_reset();
        cyc(2);

        // Presses on every other tick, including while airborne.
        for (int k = 0; k < 60; k++) step("repress", (k % 2 == 0) ? 8'h01 : 8'h00, 0);

        // Duck while grounded, then jump out of the duck.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step("duck", 8'h02, 0);
            if (k == 1)  check("duck_first", 32'(ducking), 1);
            if (k == 5)  check("duck_frame5", 32'(run_frame), 0);
            if (k == 6)  check("duck_frame6", 32'(run_frame), 1);
            if (k == 11) check("duck_frame11", 32'(run_frame), 1);
            if (k == 12) check("duck_frame12", 32'(run_frame), 0);
        end
        step("duck_jump", 8'h03, 0);
        check("duckjump_air", 32'(airborne), 1);
        check("duckjump_duck", 32'(ducking), 0);

        // Game over at the apex, then replay.
        do_reset();
        step("go_start", 8'h01, 0);
        for (int k = 0; k < 12; k++) step("go_rise", 8'h00, 0);
        for (int k = 0; k < 4; k++) step("go_frozen", 8'h00, 1);
        check("go_frozen_y", 32'(dino_y), 170);
        step("go_replay", 8'h00, 0);
        check("replay_y", 32'(dino_y), 248);
        check("replay_count", 32'(jump_count), 0);
        check("replay_air", 32'(airborne), 0);

        // Replay edge coinciding with a tick, with a jump press pending.
        step("sim_start", 8'h01, 0);
        step("sim_rise", 8'h00, 0);
        step("sim_go", 8'h00, 1);
        controller_report = 8'h01;
        model_apply(8'h01, 1);
        cyc(6);
        tick = 1'b1;
        game_over = 1'b0;
        model_apply(8'h01, 0);
        cyc(1);
        tick = 1'b0;
        push_expected();
        cyc(2);
        compare_outputs("sim_replay");
        step("sim_after", 8'h00, 0);
        check("sim_after_air", 32'(airborne), 0);

`ifdef DINO_FAST_FALL_EN
        do_reset();
        step("ff_start", 8'h01, 0);
        for (int k = 0; k < 3; k++) step("ff_rise", 8'h00, 0);
        check("ff_y_t3", 32'(dino_y), 215);
        step("ff1", 8'h02, 0);
        check("ff_y1", 32'(dino_y), 230);
        step("ff2", 8'h02, 0);
        check("ff_y2", 32'(dino_y), 245);
        step("ff3", 8'h02, 0);
        check("ff_y3", 32'(dino_y), 248);
        check("ff_air", 32'(airborne), 0);
`endif

        // Random traffic.
        do_reset();
        go = 0;
        for (int k = 0; k < 400; k++) begin
            rep = 8'($urandom);
            rep[0] = ($urandom_range(0, 2) == 0);
            rep[1] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) go = !go;
            step("rnd", rep, go);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dino_jump_ctrl.md
Name: dino_jump_ctrl

Overview:
Dino vertical-motion controller. Sits directly upstream of the game/render stage and drives its dino Y position and dino status flags. Converts the raw controller report into jump and duck actions, and integrates a fixed-point-free gravity model once per physics tick. Freezes while the game is over.

Parameters:
GROUND_Y, 248, resting Y of the dino's top edge, in pixels (matches the obstacle baseline)
CEIL_Y, 16, minimum Y the dino may reach
JUMP_VEL, 12, initial upward velocity, in pixels per tick
GRAVITY, 1, velocity change per tick
MAX_FALL, 15, maximum downward velocity, in pixels per tick
JUMP_BIT, 0, controller_report bit for jump
DUCK_BIT, 1, controller_report bit for duck
RUN_DIV, 6, ticks per run-animation frame toggle

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
controller_report  in  8  raw button report; level-sensitive, asynchronous to ticks
tick  in  1  one-cycle physics-tick pulse (same cadence as obstacle motion)
game_over  in  1  high while collision/replay screen is active
dino_y  out  11  current dino top-edge Y
airborne  out  1  high in RISE or FALL
ducking  out  1  high in DUCK
run_frame  out  1  run-animation frame select
jump_count  out  8  saturating count of jumps started

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - dino_y=GROUND_Y, airborne=0, ducking=0, run_frame=0, jump_count=0.
  - state=GROUND, vel=0, jump_req=0, prev_jump=0.
- Input capture:
  - controller_report is passed through a 2-flop synchroniser.
  - A rising edge on the synchronised JUMP_BIT sets jump_req (sticky).
  - jump_req clears on every tick cycle, whether or not it was consumed. Presses are not buffered across ticks.
- Velocity: vel is an 8-bit unsigned magnitude; direction is implied by state.
- All state updates happen only on cycles with tick=1 and game_over=0. Otherwise registers hold. The synchroniser and jump_req keep running.
- GROUND:
  - jump_req -> RISE, vel=JUMP_VEL, jump_count+1 (saturating at 255).
  - Else, DUCK_BIT held -> DUCK.
  - Else, stay in GROUND. The run divider counts; run_frame toggles every RUN_DIV ticks.
- DUCK:
  - Jump has priority: jump_req -> RISE (same updates as from GROUND).
  - DUCK_BIT released -> GROUND.
  - The run divider keeps counting in DUCK.
- RISE: dino_y <= dino_y - vel; vel <= vel - GRAVITY.
  - If (vel - GRAVITY)==0 -> FALL with vel=0.
  - Ceiling: if dino_y - vel < CEIL_Y, set dino_y=CEIL_Y and go to FALL with vel=0. Use 12-bit signed compare; no underflow wrap.
- FALL: nv=min(vel+GRAVITY, MAX_FALL); vel<=nv; dino_y<=dino_y+nv.
  - If dino_y+nv >= GROUND_Y: dino_y=GROUND_Y, vel=0, -> GROUND. Never overshoot.
- Run divider:
  - Resets to 0 on leaving GROUND/DUCK.
  - run_frame holds its value while airborne.
- Outputs are registered and follow state with 1-cycle latency after the tick cycle.
- Game over:
  - While game_over=1, everything is frozen and jump_count holds.
  - On the falling edge of game_over (replay): dino_y=GROUND_Y, vel=0, state=GROUND, jump_req=0, jump_count=0.
- Simultaneous events:
  - tick together with a game_over falling edge: the replay reset wins; no motion that cycle.
  - A jump edge on the same cycle as tick is captured for the following tick, not the current one.
- Defaults yield a symmetric arc: 12 ticks rising to apex Y=170, then 12 ticks falling back to 248. Total 24 ticks.

Optional Feature:
DINO_FAST_FALL_EN
- Defined: DUCK_BIT held at a tick while in RISE or FALL forces FALL with vel=MAX_FALL. Normal FALL stepping and ground clamp then apply, and ducking stays 0 while airborne.
- Undefined: DUCK_BIT is ignored while airborne.

Test Plan:
- Reset mid-jump (assert at tick 5 of a jump) -> next cycle dino_y=248, airborne=0, jump_count=0.
- Single jump press, then 30 ticks -> Y after ticks 1,2,12 = 236,225,170; airborne falls at tick 24 with dino_y=248; jump_count=1.
- Jump presses on every tick while airborne -> no re-jump until grounded; jump_count increments by exactly 1 per landing+press.
- Hold duck while grounded 12 ticks -> ducking=1 at first tick, run_frame toggles at ticks 6 and 12. Jump pressed while ducking -> RISE, ducking=0.
- game_over raised at apex (dino_y=170) and ticks continue -> dino_y frozen at 170. Then game_over falls -> dino_y=248, state GROUND, jump_count=0.
- With DINO_FAST_FALL_EN, duck at tick 3 of a jump (dino_y=215) -> next ticks Y=230, then 245, then clamp 248; airborne=0.
